// File: rtl/multiplexor_display_4dig_if.sv
// Bus between a value producer and the 4-digit display scanner.
// The producer (master) supplies the value, the load strobe and the enable.
// The scanner (slave) returns the current digit nibble, anodes, index and load pulse.
interface multiplexor_display_4dig_if;
    logic [15:0] i_Dato;
    logic        i_Cargar;
    logic        i_Habilitar;
    logic [3:0]  o_Bits;
    logic [3:0]  o_Anodos;
    logic [1:0]  o_Digito;
    logic        o_Cargado;

    modport master (
        output i_Dato,
        output i_Cargar,
        output i_Habilitar,
        input  o_Bits,
        input  o_Anodos,
        input  o_Digito,
        input  o_Cargado
    );

    modport slave (
        input  i_Dato,
        input  i_Cargar,
        input  i_Habilitar,
        output o_Bits,
        output o_Anodos,
        output o_Digito,
        output o_Cargado
    );
endinterface

// File: rtl/multiplexor_display_4dig.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// A prescaler advances the digit index once per slot. New values are held in a
// pending register and only reach the display register at a frame boundary
// (tick while on digit 3), so one frame never shows a mix of two values.
// Outputs are registered one cycle behind the index and display register.
module multiplexor_display_4dig #(
    parameter int unsigned P_PRESCALE      = 50000,
    parameter bit          P_SUPRIME_CEROS = 1'b1
) (
    input logic                      i_Clk,
    input logic                      i_Reset,
    multiplexor_display_4dig_if.slave bus
);

    localparam int unsigned CntW = (P_PRESCALE > 2) ? $clog2(P_PRESCALE) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(P_PRESCALE - 1);

    logic [CntW-1:0] count_q;
    logic [1:0]      index_q;
    logic [15:0]     disp_q;
    logic [15:0]     pend_q;
    logic            pend_flag_q;
    logic [3:0]      bits_q;
    logic [3:0]      anodos_q;
    logic [1:0]      digito_q;
    logic            cargado_q;

    logic            tick;
    logic            boundary;
    logic            blank;
    logic [3:0]      nibble;
    logic [3:0]      anodos_d;

    // Slot timing, current nibble, leading-zero blanking and anode pattern.
    always_comb begin
        tick     = (count_q == LastCount);
        boundary = tick && (index_q == 2'd3);
        nibble   = disp_q[{index_q, 2'b00} +: 4];
        blank    = 1'b0;
        if (P_SUPRIME_CEROS) begin
            case (index_q)
                2'd3:    blank = (disp_q[15:12] == 4'h0);
                2'd2:    blank = (disp_q[15:8] == 8'h00);
                2'd1:    blank = (disp_q[15:4] == 12'h000);
                default: blank = 1'b0;
            endcase
        end
        anodos_d = 4'b1111;
        if (bus.i_Habilitar && !blank) begin
            anodos_d[index_q] = 1'b0;
        end
    end

    // Prescaler, index, load/transfer bookkeeping and registered outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            count_q     <= '0;
            index_q     <= 2'd0;
            disp_q      <= 16'h0000;
            pend_q      <= 16'h0000;
            pend_flag_q <= 1'b0;
            bits_q      <= 4'h0;
            anodos_q    <= 4'b1111;
            digito_q    <= 2'd0;
            cargado_q   <= 1'b0;
        end else begin
            count_q <= tick ? '0 : count_q + CntW'(1);
            if (tick) begin
                index_q <= index_q + 2'd1;
            end

            cargado_q <= 1'b0;
            if (boundary && bus.i_Cargar) begin
                // A load landing on the boundary goes straight to the display.
                disp_q      <= bus.i_Dato;
                pend_flag_q <= 1'b0;
                cargado_q   <= 1'b1;
            end else if (boundary && pend_flag_q) begin
                disp_q      <= pend_q;
                pend_flag_q <= 1'b0;
                cargado_q   <= 1'b1;
            end else if (bus.i_Cargar) begin
                pend_q      <= bus.i_Dato;
                pend_flag_q <= 1'b1;
            end

            bits_q   <= nibble;
            anodos_q <= anodos_d;
            digito_q <= index_q;
        end
    end

    assign bus.o_Bits    = bits_q;
    assign bus.o_Anodos  = anodos_q;
    assign bus.o_Digito  = digito_q;
    assign bus.o_Cargado = cargado_q;

endmodule

// File: tb/tb_multiplexor_display_4dig.sv
// Directed bench for the 4-digit display scanner. Two instances run in lockstep
// on the same inputs: one with leading-zero blanking, one without.
// The bench tracks the cycle number since reset release to know where each
// slot and frame boundary falls (4 cycles per slot, 16 per frame).
module tb_multiplexor_display_4dig;

    logic clk = 1'b0;
    logic reset;

    multiplexor_display_4dig_if bus0 ();
    multiplexor_display_4dig_if bus1 ();

    assign bus1.i_Dato      = bus0.i_Dato;
    assign bus1.i_Cargar    = bus0.i_Cargar;
    assign bus1.i_Habilitar = bus0.i_Habilitar;

    multiplexor_display_4dig #(
        .P_PRESCALE      (4),
        .P_SUPRIME_CEROS (1'b1)
    ) dut0 (
        .i_Clk   (clk),
        .i_Reset (reset),
        .bus     (bus0)
    );

    multiplexor_display_4dig #(
        .P_PRESCALE      (4),
        .P_SUPRIME_CEROS (1'b0)
    ) dut1 (
        .i_Clk   (clk),
        .i_Reset (reset),
        .bus     (bus1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected anode pattern for digit d of value v.
    function automatic logic [3:0] exp_an(input logic [15:0] v, input int d, input bit supp,
                                          input bit en);
        logic [3:0] a;
        a = 4'b1111;
        if (!en) return a;
        if (supp && d == 3 && v[15:12] == 4'h0) return a;
        if (supp && d == 2 && v[15:8] == 8'h00) return a;
        if (supp && d == 1 && v[15:4] == 12'h000) return a;
        a[d] = 1'b0;
        return a;
    endfunction

    // Expected {o_Digito, o_Bits, o_Anodos, o_Cargado}.
    function automatic logic [10:0] exp_state(input logic [15:0] v, input int d, input bit supp,
                                              input bit en, input bit carg);
        logic [1:0] dd;
        dd = d[1:0];
        return {dd, v[4*d +: 4], exp_an(v, d, supp, en), carg};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        logic [10:0] a0, a1, e;
        bus0.i_Habilitar = 1'b1;
        bus0.i_Dato      = 16'hFFFF;
        bus0.i_Cargar    = 1'b1;
        reset            = 1'b1;
        step();
        bus0.i_Cargar = 1'b0;
        reset         = 1'b0;
        e  = {2'd0, 4'h0, 4'b1111, 1'b0};
        a0 = {bus0.o_Digito, bus0.o_Bits, bus0.o_Anodos, bus0.o_Cargado};
        a1 = {bus1.o_Digito, bus1.o_Bits, bus1.o_Anodos, bus1.o_Cargado};
        checks++;
        if (a0 !== e) begin
            errors++;
            $display("FAIL reset_state supp=1: got dig/bits/an/ld=%b expected %b", a0, e);
        end
        checks++;
        if (a1 !== e) begin
            errors++;
            $display("FAIL reset_state supp=0: got dig/bits/an/ld=%b expected %b", a1, e);
        end
        cyc = 0;
        // First frame after reset shows zero; the load seen during reset is gone.
        for (int c = 1; c <= 16; c++) begin
            step();
            a0 = {bus0.o_Digito, bus0.o_Bits, bus0.o_Anodos, bus0.o_Cargado};
            a1 = {bus1.o_Digito, bus1.o_Bits, bus1.o_Anodos, bus1.o_Cargado};
            checks++;
            if (a0 !== exp_state(16'h0000, (c - 1) / 4, 1'b1, 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL reset_frame cyc=%0d supp=1: got %b expected %b", cyc, a0,
                         exp_state(16'h0000, (c - 1) / 4, 1'b1, 1'b1, 1'b0));
            end
            checks++;
            if (a1 !== exp_state(16'h0000, (c - 1) / 4, 1'b0, 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL reset_frame cyc=%0d supp=0: got %b expected %b", cyc, a1,
                         exp_state(16'h0000, (c - 1) / 4, 1'b0, 1'b1, 1'b0));
            end
        end
    endtask

    task automatic test_frames();
        logic [15:0] vals [3] = '{16'h1234, 16'h0005, 16'h0000};
        logic [15:0] prev, v;
        logic [10:0] a0, a1, e0, e1;
        prev = 16'h0000;
        foreach (vals[i]) begin
            for (int c = 1; c <= 32; c++) begin
                bus0.i_Dato   = vals[i];
                bus0.i_Cargar = (c == 1);
                step();
                v  = (c <= 16) ? prev : vals[i];
                e0 = exp_state(v, ((c - 1) / 4) % 4, 1'b1, 1'b1, c == 16);
                e1 = exp_state(v, ((c - 1) / 4) % 4, 1'b0, 1'b1, c == 16);
                a0 = {bus0.o_Digito, bus0.o_Bits, bus0.o_Anodos, bus0.o_Cargado};
                a1 = {bus1.o_Digito, bus1.o_Bits, bus1.o_Anodos, bus1.o_Cargado};
                checks++;
                if (a0 !== e0) begin
                    errors++;
                    $display("FAIL frame_%h cyc=%0d supp=1: got %b expected %b", vals[i], cyc,
                             a0, e0);
                end
                checks++;
                if (a1 !== e1) begin
                    errors++;
                    $display("FAIL frame_%h cyc=%0d supp=0: got %b expected %b", vals[i], cyc,
                             a1, e1);
                end
            end
            bus0.i_Cargar = 1'b0;
            prev = vals[i];
        end
    endtask

    task automatic test_latest_wins();
        logic [15:0] v;
        logic [10:0] a0, e0;
        int pulses = 0;
        for (int c = 1; c <= 32; c++) begin
            bus0.i_Dato   = (c == 1) ? 16'h1111 : 16'h2222;
            bus0.i_Cargar = (c == 1 || c == 5);
            step();
            if (bus0.o_Cargado === 1'b1) pulses++;
            v  = (c <= 16) ? 16'h0000 : 16'h2222;
            e0 = exp_state(v, ((c - 1) / 4) % 4, 1'b1, 1'b1, c == 16);
            a0 = {bus0.o_Digito, bus0.o_Bits, bus0.o_Anodos, bus0.o_Cargado};
            checks++;
            if (a0 !== e0) begin
                errors++;
                $display("FAIL latest_wins cyc=%0d: got %b expected %b", cyc, a0, e0);
            end
        end
        bus0.i_Cargar = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL latest_wins_pulses: got %0d pulses expected 1", pulses);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] v;
        logic [10:0] a0, a1, e0, e1;
        for (int c = 1; c <= 32; c++) begin
            bus0.i_Dato   = 16'hABCD;
            bus0.i_Cargar = (c == 16);
            step();
            v  = (c <= 16) ? 16'h2222 : 16'hABCD;
            e0 = exp_state(v, ((c - 1) / 4) % 4, 1'b1, 1'b1, c == 16);
            e1 = exp_state(v, ((c - 1) / 4) % 4, 1'b0, 1'b1, c == 16);
            a0 = {bus0.o_Digito, bus0.o_Bits, bus0.o_Anodos, bus0.o_Cargado};
            a1 = {bus1.o_Digito, bus1.o_Bits, bus1.o_Anodos, bus1.o_Cargado};
            checks++;
            if (a0 !== e0) begin
                errors++;
                $display("FAIL bypass cyc=%0d supp=1: got %b expected %b", cyc, a0, e0);
            end
            checks++;
            if (a1 !== e1) begin
                errors++;
                $display("FAIL bypass cyc=%0d supp=0: got %b expected %b", cyc, a1, e1);
            end
        end
        bus0.i_Cargar = 1'b0;
    endtask

    task automatic test_reset_pending();
        logic [10:0] a0, e0;
        for (int c = 1; c <= 5; c++) begin
            bus0.i_Dato   = 16'h5555;
            bus0.i_Cargar = (c == 2);
            step();
            e0 = exp_state(16'hABCD, (c - 1) / 4, 1'b1, 1'b1, 1'b0);
            a0 = {bus0.o_Digito, bus0.o_Bits, bus0.o_Anodos, bus0.o_Cargado};
            checks++;
            if (a0 !== e0) begin
                errors++;
                $display("FAIL pre_reset cyc=%0d: got %b expected %b", cyc, a0, e0);
            end
        end
        bus0.i_Cargar = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        e0 = {2'd0, 4'h0, 4'b1111, 1'b0};
        a0 = {bus0.o_Digito, bus0.o_Bits, bus0.o_Anodos, bus0.o_Cargado};
        checks++;
        if (a0 !== e0) begin
            errors++;
            $display("FAIL mid_reset_state: got %b expected %b", a0, e0);
        end
        cyc = 0;
        // The discarded pending value must never surface.
        for (int c = 1; c <= 32; c++) begin
            step();
            e0 = exp_state(16'h0000, ((c - 1) / 4) % 4, 1'b1, 1'b1, 1'b0);
            a0 = {bus0.o_Digito, bus0.o_Bits, bus0.o_Anodos, bus0.o_Cargado};
            checks++;
            if (a0 !== e0) begin
                errors++;
                $display("FAIL post_reset cyc=%0d: got %b expected %b", cyc, a0, e0);
            end
        end
    endtask

    task automatic test_disable();
        logic [10:0] a0, a1, e0, e1;
        bit en;
        for (int c = 1; c <= 16; c++) begin
            en = !(c >= 3 && c <= 9);
            bus0.i_Habilitar = en;
            step();
            e0 = exp_state(16'h0000, (c - 1) / 4, 1'b1, en, 1'b0);
            e1 = exp_state(16'h0000, (c - 1) / 4, 1'b0, en, 1'b0);
            a0 = {bus0.o_Digito, bus0.o_Bits, bus0.o_Anodos, bus0.o_Cargado};
            a1 = {bus1.o_Digito, bus1.o_Bits, bus1.o_Anodos, bus1.o_Cargado};
            checks++;
            if (a0 !== e0) begin
                errors++;
                $display("FAIL disable cyc=%0d supp=1: got %b expected %b", cyc, a0, e0);
            end
            checks++;
            if (a1 !== e1) begin
                errors++;
                $display("FAIL disable cyc=%0d supp=0: got %b expected %b", cyc, a1, e1);
            end
        end
        bus0.i_Habilitar = 1'b1;
    endtask

    initial begin
        reset            = 1'b1;
        bus0.i_Dato      = 16'h0000;
        bus0.i_Cargar    = 1'b0;
        bus0.i_Habilitar = 1'b1;
        #2;
        test_reset();
        test_frames();
        test_latest_wins();
        test_bypass();
        test_reset_pending();
        test_disable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1);
    end

endmodule
